// File: rtl/datapath_pkg.sv
// Shared encodings for the two-stage datapath: opcode/ext codes,
// flag bit positions, instruction fields and the instruction decoder.
package datapath_pkg;

  localparam logic [3:0] OP_REG = 4'h0;

  localparam logic [3:0] X_AND  = 4'h1;
  localparam logic [3:0] X_OR   = 4'h2;
  localparam logic [3:0] X_XOR  = 4'h3;
  localparam logic [3:0] X_ADD  = 4'h5;
  localparam logic [3:0] X_ADDC = 4'h7;
  localparam logic [3:0] X_SUB  = 4'h9;
  localparam logic [3:0] X_CMP  = 4'hB;
  localparam logic [3:0] X_MOV  = 4'hD;

  localparam int F_C = 4;
  localparam int F_L = 3;
  localparam int F_F = 2;
  localparam int F_Z = 1;
  localparam int F_N = 0;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int EXT_HI = 7;
  localparam int EXT_LO = 4;
  localparam int RS_HI  = 3;
  localparam int RS_LO  = 0;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_ADDC,
    ALU_SUB,
    ALU_CMP,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_MOV
  } alu_op_e;

  typedef struct packed {
    logic    legal;
    logic    imm;
    logic    wr;
    alu_op_e op;
  } dec_t;

  function automatic dec_t decode(input logic [15:0] inst);
    dec_t d;
    logic [3:0] op;
    logic [3:0] code;
    op      = inst[OP_HI:OP_LO];
    d.imm   = (op != OP_REG);
    code    = d.imm ? op : inst[EXT_HI:EXT_LO];
    d.legal = 1'b1;
    d.op    = ALU_MOV;
    case (code)
      X_ADD:  d.op = ALU_ADD;
      X_SUB:  d.op = ALU_SUB;
      X_CMP:  d.op = ALU_CMP;
      X_AND:  d.op = ALU_AND;
      X_OR:   d.op = ALU_OR;
      X_XOR:  d.op = ALU_XOR;
      X_MOV:  d.op = ALU_MOV;
      X_ADDC: begin
        d.op    = ALU_ADDC;
        d.legal = !d.imm;
      end
      default: d.legal = 1'b0;
    endcase
    d.wr = d.legal && (d.op != ALU_CMP);
    return d;
  endfunction

endpackage

// File: rtl/pd_alu.sv
// Combinational ALU: result, new flag values and the mask of
// flags this operation is allowed to update.
module pd_alu
  import datapath_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  input  alu_op_e          op_i,
  output logic [WIDTH-1:0] res_o,
  output logic [4:0]       flags_o,
  output logic [4:0]       mask_o
);

  localparam int MSB = WIDTH - 1;

  logic           cin;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] dif;

  assign cin = c_i && (op_i == ALU_ADDC);
  assign sum = {1'b0, a_i} + {1'b0, b_i}
             + {{WIDTH{1'b0}}, cin};
  // top bit of the extended difference is the borrow
  assign dif = {1'b0, a_i} - {1'b0, b_i};

  always_comb begin
    res_o   = '0;
    flags_o = '0;
    mask_o  = '0;
    case (op_i)
      ALU_ADD, ALU_ADDC: begin
        res_o        = sum[MSB:0];
        flags_o[F_C] = sum[WIDTH];
        flags_o[F_F] = (a_i[MSB] == b_i[MSB])
                    && (sum[MSB] != a_i[MSB]);
        mask_o[F_C]  = 1'b1;
        mask_o[F_F]  = 1'b1;
      end
      ALU_SUB: begin
        res_o        = dif[MSB:0];
        flags_o[F_C] = dif[WIDTH];
        flags_o[F_F] = (a_i[MSB] != b_i[MSB])
                    && (dif[MSB] != a_i[MSB]);
        mask_o[F_C]  = 1'b1;
        mask_o[F_F]  = 1'b1;
      end
      ALU_CMP: begin
        res_o        = dif[MSB:0];
        flags_o[F_Z] = (a_i == b_i);
        flags_o[F_L] = dif[WIDTH];
        flags_o[F_N] = $signed(a_i) < $signed(b_i);
        mask_o[F_Z]  = 1'b1;
        mask_o[F_L]  = 1'b1;
        mask_o[F_N]  = 1'b1;
      end
      ALU_AND: res_o = a_i & b_i;
      ALU_OR:  res_o = a_i | b_i;
      ALU_XOR: res_o = a_i ^ b_i;
      ALU_MOV: res_o = b_i;
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/pipelined_datapath.sv
// Two-stage datapath: stage 1 decodes and captures operands,
// stage 2 runs the ALU and retires into regs, bus and flags.
module pipelined_datapath
  import datapath_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inst_valid,
  input  logic [15:0]      inst,
  output logic [WIDTH-1:0] bus_output,
  output logic             out_valid,
  output logic [4:0]       flags_output
);

  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [4:0] NR = 5'(NREGS);

  logic [WIDTH-1:0] rf_q [NREGS];

  logic             s1_v_q;
  logic             s1_wr_q;
  alu_op_e          s1_op_q;
  logic [3:0]       s1_rd_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;

  logic [WIDTH-1:0] bus_q;
  logic             ov_q;
  logic [4:0]       flags_q;

  dec_t             dec;
  logic [3:0]       rd_idx;
  logic [3:0]       rs_idx;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] b_d;
  logic             wr_d;

  logic [WIDTH-1:0] alu_res;
  logic [4:0]       alu_flags;
  logic [4:0]       alu_mask;

  assign dec    = decode(inst);
  assign rd_idx = inst[RD_HI:RD_LO];
  assign rs_idx = inst[RS_HI:RS_LO];
  assign imm    = WIDTH'($signed(inst[EXT_HI:RS_LO]));
  assign wr_d   = dec.wr && ({1'b0, rd_idx} < NR);

  // the instruction in stage 2 writes at this same edge, so bypass it
  always_comb begin
    a_d    = '0;
    rs_val = '0;
    if ({1'b0, rd_idx} < NR)
      a_d = rf_q[rd_idx[IW-1:0]];
    if (s1_v_q && s1_wr_q && (s1_rd_q == rd_idx))
      a_d = alu_res;
    if ({1'b0, rs_idx} < NR)
      rs_val = rf_q[rs_idx[IW-1:0]];
    if (s1_v_q && s1_wr_q && (s1_rd_q == rs_idx))
      rs_val = alu_res;
    b_d = dec.imm ? imm : rs_val;
  end

  // carry comes straight from flags_q: the prior op has retired by now
  pd_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a_i    (s1_a_q),
    .b_i    (s1_b_q),
    .c_i    (flags_q[F_C]),
    .op_i   (s1_op_q),
    .res_o  (alu_res),
    .flags_o(alu_flags),
    .mask_o (alu_mask)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v_q  <= 1'b0;
      s1_wr_q <= 1'b0;
      s1_op_q <= ALU_MOV;
      s1_rd_q <= '0;
      s1_a_q  <= '0;
      s1_b_q  <= '0;
      bus_q   <= '0;
      ov_q    <= 1'b0;
      flags_q <= '0;
      for (int i = 0; i < NREGS; i++)
        rf_q[i] <= '0;
    end else begin
      s1_v_q  <= inst_valid && dec.legal;
      s1_wr_q <= wr_d;
      s1_op_q <= dec.op;
      s1_rd_q <= rd_idx;
      s1_a_q  <= a_d;
      s1_b_q  <= b_d;
      ov_q    <= s1_v_q;
      if (s1_v_q) begin
        bus_q   <= alu_res;
        flags_q <= (flags_q & ~alu_mask)
                 | (alu_flags & alu_mask);
        if (s1_wr_q)
          rf_q[s1_rd_q[IW-1:0]] <= alu_res;
      end
    end
  end

  assign bus_output   = bus_q;
  assign out_valid    = ov_q;
  assign flags_output = flags_q;

endmodule

// File: tb/tb_pipelined_datapath.sv
// Scoreboard bench: an arithmetic reference model predicts each
// retirement; a monitor checks timing, result and flags.
module tb_pipelined_datapath;

  localparam int W  = 16;
  localparam int NR = 8;
  localparam longint MOD = 64'd1 << W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          inst_valid = 1'b0;
  logic [15:0]   inst = '0;
  logic [W-1:0]  bus_output;
  logic          out_valid;
  logic [4:0]    flags_output;

  always #5 clk = ~clk;

  pipelined_datapath #(
    .WIDTH(W),
    .NREGS(NR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .bus_output  (bus_output),
    .out_valid   (out_valid),
    .flags_output(flags_output)
  );

  typedef struct {
    int           due;
    logic [W-1:0] res;
    logic [4:0]   fl;
  } exp_t;

  exp_t         sbq[$];
  int           checks = 0;
  int           errors = 0;
  int           edge_n = 0;
  longint       m_regs[16];
  logic [4:0]   m_flags = '0;
  logic [W-1:0] last_bus = '0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)",
               nm, act, exp, edge_n);
    end
  endtask

  function automatic longint sgn(input longint v);
    return (v >= MOD / 2) ? v - MOD : v;
  endfunction

  // Reference model: executes one instruction in program order.
  function automatic bit model(input logic [15:0] i,
                               output logic [W-1:0] r,
                               output logic [4:0] f);
    int op, ext, rd, rs, code;
    bit imm, legal;
    longint a, b, sa, sb, t, ts, res, cin;
    op   = int'(i[15:12]);
    ext  = int'(i[7:4]);
    rd   = int'(i[11:8]);
    rs   = int'(i[3:0]);
    imm  = (op != 0);
    code = imm ? op : ext;
    legal = (code inside {5, 9, 11, 1, 2, 3, 13})
         || (code == 7 && !imm);
    f = m_flags;
    r = '0;
    if (!legal) return 1'b0;
    a = (rd < NR) ? m_regs[rd] : 0;
    if (imm)
      b = i[7] ? longint'(i[7:0]) + MOD - 256
               : longint'(i[7:0]);
    else
      b = (rs < NR) ? m_regs[rs] : 0;
    sa  = sgn(a);
    sb  = sgn(b);
    res = 0;
    case (code)
      5, 7: begin
        cin  = (code == 7) ? longint'(f[4]) : 0;
        t    = a + b + cin;
        ts   = sa + sb + cin;
        res  = t % MOD;
        f[4] = (t >= MOD);
        f[2] = (ts >= MOD / 2) || (ts < -(MOD / 2));
      end
      9: begin
        ts   = sa - sb;
        res  = (a - b + MOD) % MOD;
        f[4] = (a < b);
        f[2] = (ts >= MOD / 2) || (ts < -(MOD / 2));
      end
      11: begin
        res  = (a - b + MOD) % MOD;
        f[1] = (a == b);
        f[3] = (a < b);
        f[0] = (sa < sb);
      end
      1:  res = a & b;
      2:  res = a | b;
      3:  res = a ^ b;
      default: res = b;
    endcase
    r = res[W-1:0];
    if (code != 11 && rd < NR) m_regs[rd] = res;
    m_flags = f;
    return 1'b1;
  endfunction

  task automatic issue(input logic [15:0] i, input bit v);
    logic [W-1:0] r;
    logic [4:0]   f;
    @(posedge clk);
    #2;
    reset      = 1'b0;
    inst_valid = v;
    inst       = i;
    if (v && model(i, r, f))
      sbq.push_back('{edge_n + 2, r, f});
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #2;
    reset      = 1'b1;
    inst_valid = 1'($urandom % 2);
    inst       = 16'($urandom);
    sbq.delete();
    foreach (m_regs[k]) m_regs[k] = 0;
    m_flags = '0;
    repeat (n - 1) @(posedge clk);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      edge_n++;
      if (reset) begin
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_bus", 32'(bus_output), 32'd0);
        chk("rst_flags", 32'(flags_output), 32'd0);
        last_bus = '0;
      end else begin
        while (sbq.size() > 0 && sbq[0].due < edge_n) begin
          checks++;
          errors++;
          $display("FAIL latency: result %h due edge %0d not seen",
                   sbq[0].res, sbq[0].due);
          void'(sbq.pop_front());
        end
        if (out_valid) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious: out_valid bus %h at edge %0d",
                     bus_output, edge_n);
          end else begin
            e = sbq.pop_front();
            chk("retire_edge", 32'(edge_n), 32'(e.due));
            chk("bus", 32'(bus_output), 32'(e.res));
            chk("flags", 32'(flags_output), 32'(e.fl));
          end
          last_bus = bus_output;
        end else begin
          chk("bus_hold", 32'(bus_output), 32'(last_bus));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Driver
  initial begin
    logic [3:0] codes[8];
    logic [3:0] op, ext, rd, rs;
    int sel;
    codes = '{4'h5, 4'h7, 4'h9, 4'hB, 4'h1, 4'h2, 4'h3, 4'hD};
    do_reset(2);
    // forwarding chain
    issue(16'hD002, 1);
    issue(16'hD105, 1);
    issue(16'h0150, 1);
    // carry out, then ADDC consumes it
    issue(16'hD2FF, 1);
    issue(16'h5201, 1);
    issue(16'h0373, 1);
    // build 0x7FFF in r4, overflow it, compare
    issue(16'hD401, 1);
    repeat (15) issue(16'h0454, 1);
    issue(16'hD601, 1);
    issue(16'h0496, 1);
    issue(16'h5401, 1);
    issue(16'hB400, 1);
    issue(16'h07D4, 1);
    // index beyond NREGS
    issue(16'hD078, 1);
    issue(16'h0050, 1);
    issue(16'hD903, 1);
    issue(16'h0029, 1);
    // reset with an instruction in flight
    issue(16'h0150, 1);
    do_reset(1);
    issue(16'hD104, 1);
    issue(16'h02D1, 1);
    // bubbles and illegal ops between legal ones
    issue(16'h0594, 1);
    issue(16'h0000, 0);
    issue(16'hF5A3, 1);
    issue(16'hF000, 0);
    issue(16'h0171, 1);
    issue(16'h0000, 0);
    issue(16'hFFFF, 1);
    issue(16'h0000, 0);
    issue(16'h0050, 1);
    // random traffic
    repeat (400) begin
      if ($urandom % 80 == 0) do_reset(1 + int'($urandom % 2));
      sel = int'($urandom % 8);
      rd  = 4'($urandom % 11);
      rs  = 4'($urandom % 11);
      ext = 4'($urandom);
      case ($urandom % 4)
        0, 1: begin
          op  = 4'h0;
          ext = codes[sel];
        end
        2: op = codes[sel];
        default: op = 4'($urandom);
      endcase
      issue({op, rd, ext, rs}, ($urandom % 4) != 0);
    end
    repeat (4) issue(16'h0000, 0);
    chk("drain", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_datapath.md
PIPELINED_DATAPATH -- requirements
Module: pipelined_datapath

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, datapath/register width (8..32).
REQ-002 The block SHALL have parameter NREGS, default 16, number of general registers (2..16).
REQ-003 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port inst_valid  input  1  inst is issued this cycle.
REQ-006 The block SHALL have port inst  input  16  instruction: [15:12] op, [11:8] Rdest, [7:4] ext/imm-hi, [3:0] Rsrc/imm-lo.
REQ-007 The block SHALL have port bus_output  output  WIDTH  registered ALU result of the last retired instruction.
REQ-008 The block SHALL have port out_valid  output  1  one-cycle pulse when bus_output carries a new result.
REQ-009 The block SHALL have port flags_output  output  5  registered flags {C,L,F,Z,N}, bits [4:0].

Function
REQ-010 Register ops (op=0000), by ext: 0101 ADD, 0111 ADDC, 1001 SUB, 1011 CMP, 0001 AND, 0010 OR, 0011 XOR, 1101 MOV; result to Rdest, except CMP (no write).
REQ-011 Immediate ops (op = same ext code: 0101 ADDI, 1001 SUBI, 1011 CMPI, 0001 ANDI, 0010 ORI, 0011 XORI, 1101 MOVI) SHALL use inst[7:0] sign-extended to WIDTH in place of Rsrc.
REQ-012 Any other op/ext SHALL be a NOP: no register write, no flag change, no out_valid.
REQ-013 Pipeline SHALL be two stages: edge 1 latches decoded fields and operands; edge 2 writes Rdest, bus_output, flags, and raises out_valid; latency = 2 edges, throughput 1/cycle.
REQ-014 A source equal to the Rdest of the instruction in stage 2 SHALL be forwarded from the ALU result, never the stale register; the same applies to C for ADDC.
REQ-015 Register indices >= NREGS SHALL read as 0 and SHALL NOT be written.
REQ-016 Arithmetic SHALL be modulo 2^WIDTH; ADD/ADDC/ADDI set C = carry-out, F = signed overflow; SUB/SUBI set C = borrow, F = signed overflow.
REQ-017 CMP/CMPI SHALL compute Rdest - src and set Z = equal, L = Rdest < src unsigned, N = Rdest < src signed.
REQ-018 Flags not named for an instruction SHALL hold; logic ops and MOV SHALL change no flags.
REQ-019 A cycle with inst_valid=0 SHALL inject a bubble; out_valid SHALL be 0 two edges later, bus_output holds.
REQ-020 CMP SHALL pulse out_valid with bus_output = difference, without register write.

Reset
REQ-021 On reset=1 at an edge: all registers, bus_output, flags_output = 0; out_valid = 0; both stage-valid bits cleared.
REQ-022 Instructions in flight at reset SHALL be discarded with no write; inst_valid coincident with reset SHALL be ignored.
REQ-023 An instruction issued on the first cycle after reset deassertion SHALL execute normally.

Structure
REQ-024 Opcode/ext codes, flag bit indices and instruction field positions SHALL live in shared package datapath_pkg.
REQ-025 The combinational ALU SHALL be a sub-module pd_alu (WIDTH parameter, operands, carry-in, op -> result, flags, flag-update mask).
REQ-026 Register file, forwarding and pipeline registers SHALL reside in pipelined_datapath.

Verification
REQ-027 WIDTH=16: reset, then back-to-back MOVI r0,2; MOVI r1,5; ADD r1,r0 -> out_valid pulses on 3 consecutive cycles with bus_output 2, 5, 7 (forwarding exercised).
REQ-028 MOVI r2,-1 (0xFFFF); ADDI r2,1 -> bus_output 0x0000, C=1, F=0; then ADDC r3,r3 (r3=0) -> 0x0001.
REQ-029 r4=0x7FFF, ADDI r4,1 -> 0x8000, F=1, C=0; CMPI r4,0 -> L=0, N=1, Z=0, r4 unchanged at 0x8000.
REQ-030 NREGS=8: MOVI r9,3 then OR r0,r9 with r0=0x00F0 -> r9 unwritten, bus_output 0x00F0.
REQ-031 Issue ADD r1,r0 and assert reset on the following edge -> no out_valid, r1 = 0, flags = 0; next MOVI r1,4 retires 2 edges after issue.
REQ-032 Alternate inst_valid 1/0 with op=1111 interleaved -> out_valid only for legal instructions, flags unchanged across NOP.
